// File: rtl/block_fall_controller.sv
// BlockFall game sequencer: moves one falling cell over a 1-bit-per-cell board RAM
// and handles lateral moves, gravity, locking, full-row clears, scoring and game over.
module block_fall_controller #(
    parameter int WIDTH       = 8,
    parameter int HEIGHT      = 16,
    parameter int XBITS       = 3,
    parameter int YBITS       = 4,
    parameter int ADDR_BITS   = 7,
    parameter int FALL_FRAMES = 30,
    parameter int SPAWN_X     = 3
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 frame_tick,
    input  logic                 move_left,
    input  logic                 move_right,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic                 mem_wr,
    output logic                 mem_wdata,
    input  logic                 mem_rdata,
    output logic [XBITS-1:0]     block_x,
    output logic [YBITS-1:0]     block_y,
    output logic [15:0]          score,
    output logic                 game_over,
    output logic                 busy
);

    localparam int FBITS = (FALL_FRAMES > 1) ? $clog2(FALL_FRAMES) : 1;

    localparam logic [XBITS-1:0]     X_MAX     = XBITS'(WIDTH - 1);
    localparam logic [YBITS-1:0]     Y_MAX     = YBITS'(HEIGHT - 1);
    localparam logic [XBITS-1:0]     SPAWN     = XBITS'(SPAWN_X);
    localparam logic [FBITS-1:0]     F_MAX     = FBITS'(FALL_FRAMES - 1);
    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(WIDTH * HEIGHT - 1);

    typedef enum logic [3:0] {
        CLEAR, SPAWN_RD, SPAWN_CHK, IDLE, MOVE_RD, MOVE_CHK, GRAV,
        FALL_RD, FALL_CHK, LOCK_WR, ROW_RD, ROW_CHK, ROW_CLR, OVER
    } state_t;

    state_t                 state, next_state;
    logic [ADDR_BITS-1:0]   clr_addr;
    logic [XBITS-1:0]       target_x;
    logic [XBITS-1:0]       col;
    logic [FBITS-1:0]       fall_cnt;
    logic                   left_ok, right_ok, fall_last;

    // Row-major addressing, widened before the multiply so y*WIDTH never truncates.
    function automatic logic [ADDR_BITS-1:0] cell_addr(input logic [XBITS-1:0] x,
                                                       input logic [YBITS-1:0] y);
        cell_addr = ADDR_BITS'(y) * ADDR_BITS'(WIDTH) + ADDR_BITS'(x);
    endfunction

    assign left_ok   = move_left & ~move_right & (block_x != '0);
    assign right_ok  = move_right & ~move_left & (block_x != X_MAX);
    assign fall_last = (fall_cnt == F_MAX);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= CLEAR;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            CLEAR:     if (clr_addr == LAST_ADDR) next_state = SPAWN_RD;
            SPAWN_RD:  next_state = SPAWN_CHK;
            SPAWN_CHK: next_state = mem_rdata ? OVER : IDLE;
            IDLE:      if (frame_tick) next_state = (left_ok || right_ok) ? MOVE_RD : GRAV;
            MOVE_RD:   next_state = MOVE_CHK;
            MOVE_CHK:  next_state = GRAV;
            GRAV:      next_state = fall_last ? FALL_RD : IDLE;
            FALL_RD:   next_state = (block_y == Y_MAX) ? LOCK_WR : FALL_CHK;
            FALL_CHK:  next_state = mem_rdata ? LOCK_WR : IDLE;
            LOCK_WR:   next_state = ROW_RD;
            ROW_RD:    next_state = ROW_CHK;
            ROW_CHK: begin
                if (!mem_rdata)        next_state = SPAWN_RD;
                else if (col == X_MAX) next_state = ROW_CLR;
                else                   next_state = ROW_RD;
            end
            ROW_CLR:   if (col == X_MAX) next_state = SPAWN_RD;
            OVER:      next_state = OVER;
            default:   next_state = CLEAR;
        endcase
    end

    // Reset forces CLEAR asynchronously; the strobe is held low until reset lifts
    // so an aborted write never lands in the RAM.
    always_comb begin
        mem_addr  = '0;
        mem_wr    = 1'b0;
        mem_wdata = 1'b0;
        busy      = (state != IDLE);
        game_over = (state == OVER);
        case (state)
            CLEAR: begin
                mem_addr = clr_addr;
                mem_wr   = ~reset;
            end
            SPAWN_RD: mem_addr = cell_addr(SPAWN, '0);
            MOVE_RD:  mem_addr = cell_addr(target_x, block_y);
            FALL_RD:  if (block_y != Y_MAX) mem_addr = cell_addr(block_x, block_y + 1'b1);
            LOCK_WR: begin
                mem_addr  = cell_addr(block_x, block_y);
                mem_wr    = 1'b1;
                mem_wdata = 1'b1;
            end
            ROW_RD:   mem_addr = cell_addr(col, block_y);
            ROW_CLR: begin
                mem_addr = cell_addr(col, block_y);
                mem_wr   = 1'b1;
            end
            default: ;
        endcase
    end

    // Block position, scan counters and score advance alongside the FSM.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            clr_addr <= '0;
            target_x <= '0;
            col      <= '0;
            fall_cnt <= '0;
            block_x  <= SPAWN;
            block_y  <= '0;
            score    <= '0;
        end else begin
            case (state)
                CLEAR: clr_addr <= (clr_addr == LAST_ADDR) ? '0 : clr_addr + 1'b1;
                SPAWN_CHK: begin
                    if (!mem_rdata) begin
                        block_x  <= SPAWN;
                        block_y  <= '0;
                        fall_cnt <= '0;
                    end
                end
                IDLE: begin
                    if (frame_tick) begin
                        if (left_ok)       target_x <= block_x - 1'b1;
                        else if (right_ok) target_x <= block_x + 1'b1;
                    end
                end
                MOVE_CHK: if (!mem_rdata) block_x <= target_x;
                GRAV:     fall_cnt <= fall_last ? '0 : fall_cnt + 1'b1;
                FALL_CHK: if (!mem_rdata) block_y <= block_y + 1'b1;
                LOCK_WR:  col <= '0;
                ROW_CHK:  if (mem_rdata) col <= (col == X_MAX) ? '0 : col + 1'b1;
                ROW_CLR: begin
                    if (col == X_MAX) begin
                        col <= '0;
                        if (score != 16'hFFFF) score <= score + 1'b1;
                    end else begin
                        col <= col + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_block_fall_controller.sv
// Bench for block_fall_controller: RAM model plus a frame-level game model that
// predicts block position, board contents, score and game over after every tick.
module tb_block_fall_controller;

    localparam int W   = 8;
    localparam int H   = 16;
    localparam int FF  = 30;
    localparam int SPX = 3;

    logic       clock;
    logic       reset;
    logic       frame_tick;
    logic       move_left;
    logic       move_right;
    logic [6:0] mem_addr;
    logic       mem_wr;
    logic       mem_wdata;
    logic       mem_rdata;
    logic [2:0] block_x;
    logic [3:0] block_y;
    logic [15:0] score;
    logic       game_over;
    logic       busy;

    logic       ram [0:W*H-1];
    logic [7:0] wr_log [0:255];
    int         wr_count = 0;
    logic       pre_we;
    logic [6:0] pre_addr;
    logic       pre_data;

    bit model_board [0:H-1][0:W-1];
    int m_x, m_y, m_fall, m_score;
    bit m_over;

    int passed = 0;
    int total  = 0;

    block_fall_controller #(
        .WIDTH(W), .HEIGHT(H), .XBITS(3), .YBITS(4), .ADDR_BITS(7),
        .FALL_FRAMES(FF), .SPAWN_X(SPX)
    ) dut (
        .clock(clock), .reset(reset), .frame_tick(frame_tick),
        .move_left(move_left), .move_right(move_right),
        .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .block_x(block_x), .block_y(block_y),
        .score(score), .game_over(game_over), .busy(busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Single-port RAM with one-cycle read latency; also logs every DUT write
    // and applies bench preloads.
    always @(posedge clock) begin
        mem_rdata <= ram[mem_addr];
        if (mem_wr) begin
            ram[mem_addr] = mem_wdata;
            wr_log[wr_count % 256] = {mem_addr, mem_wdata};
            wr_count = wr_count + 1;
        end
        if (pre_we) ram[pre_addr] = pre_data;
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("[TB] FAIL %s: observed %0d, required %0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                model_board[y][x] = 1'b0;
        m_x = SPX; m_y = 0; m_fall = 0; m_score = 0; m_over = 1'b0;
    endtask

    // One frame of game rules: try the move, then count toward gravity.
    task automatic model_tick(input bit l, input bit r);
        int cand;
        bit full;
        if (m_over) return;
        cand = m_x;
        if (l && !r && m_x > 0)          cand = m_x - 1;
        else if (r && !l && m_x < W - 1) cand = m_x + 1;
        if (!model_board[m_y][cand]) m_x = cand;
        if (m_fall < FF - 1) begin
            m_fall++;
            return;
        end
        m_fall = 0;
        if (m_y < H - 1 && !model_board[m_y + 1][m_x]) begin
            m_y++;
            return;
        end
        model_board[m_y][m_x] = 1'b1;
        full = 1'b1;
        for (int c = 0; c < W; c++) full &= model_board[m_y][c];
        if (full) begin
            for (int c = 0; c < W; c++) model_board[m_y][c] = 1'b0;
            if (m_score < 65535) m_score++;
        end
        if (model_board[0][SPX]) m_over = 1'b1;
        else begin
            m_x = SPX;
            m_y = 0;
        end
    endtask

    task automatic preload_raw(input int addr, input bit d);
        @(negedge clock);
        pre_addr = 7'(addr);
        pre_data = d;
        pre_we   = 1'b1;
        @(negedge clock);
        pre_we   = 1'b0;
    endtask

    task automatic preload_cell(input int x, input int y);
        preload_raw(y * W + x, 1'b1);
        model_board[y][x] = 1'b1;
    endtask

    task automatic check_board(input string tag);
        int mism;
        mism = 0;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                if (ram[y * W + x] !== model_board[y][x]) mism++;
        check_output(tag, mism, 0);
    endtask

    task automatic check_model(input string tag);
        check_output({tag, "_x"}, block_x, m_x);
        check_output({tag, "_y"}, block_y, m_y);
        check_output({tag, "_score"}, score, m_score);
        check_output({tag, "_over"}, game_over, m_over);
    endtask

    task automatic wait_ready(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (!busy || game_over) begin
                ok = 1'b1;
                break;
            end
            @(negedge clock);
        end
        check_output(tag, ok, 1);
    endtask

    task automatic apply_stimulus(input bit l, input bit r);
        @(negedge clock);
        frame_tick = 1'b1;
        move_left  = l;
        move_right = r;
        @(negedge clock);
        frame_tick = 1'b0;
        model_tick(l, r);
        wait_ready("tick_ready");
        check_model("tick");
    endtask

    task automatic check_reset_values(input string tag);
        check_output({tag, "_block_x"}, block_x, SPX);
        check_output({tag, "_block_y"}, block_y, 0);
        check_output({tag, "_score"}, score, 0);
        check_output({tag, "_game_over"}, game_over, 0);
        check_output({tag, "_busy"}, busy, 1);
        check_output({tag, "_mem_wr"}, mem_wr, 0);
        check_output({tag, "_mem_addr"}, mem_addr, 0);
        check_output({tag, "_mem_wdata"}, mem_wdata, 0);
    endtask

    task automatic release_and_check_clear();
        int cycles, base, bad;
        bit done;
        logic [7:0] entry;
        base   = wr_count;
        cycles = 0;
        done   = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clock);
            cycles++;
            if (!busy) begin
                done = 1'b1;
                break;
            end
        end
        check_output("clear_done", done, 1);
        check_output("clear_cycles", cycles, W * H + 2);
        check_output("clear_writes", wr_count - base, W * H);
        bad = 0;
        for (int i = 0; i < W * H; i++) begin
            entry = wr_log[(base + i) % 256];
            if (entry[7:1] !== 7'(i) || entry[0] !== 1'b0) bad++;
        end
        check_output("clear_order", bad, 0);
        model_reset();
        check_board("clear_board");
        check_model("spawn");
        check_output("spawn_busy", busy, 0);
    endtask

    initial begin
        int base, x0;
        bit found;
        logic [7:0] entry;

        reset = 1'b1; frame_tick = 1'b0; move_left = 1'b0; move_right = 1'b0;
        pre_we = 1'b0; pre_addr = '0; pre_data = 1'b0;

        // Board starts full of garbage so the clear pass is observable.
        for (int a = 0; a < W * H; a++) preload_raw(a, 1'($urandom_range(0, 1)));
        check_reset_values("rst");
        release_and_check_clear();

        // Gravity: first step on the 30th tick, bottom reached after 450 ticks.
        for (int t = 0; t < 29; t++) apply_stimulus(1'b0, 1'b0);
        check_output("grav_29", block_y, 0);
        apply_stimulus(1'b0, 1'b0);
        check_output("grav_30", block_y, 1);
        for (int t = 30; t < 15 * FF; t++) apply_stimulus(1'b0, 1'b0);
        check_output("grav_bottom", block_y, 15);
        base = wr_count;
        for (int t = 0; t < FF; t++) apply_stimulus(1'b0, 1'b0);
        entry = wr_log[base % 256];
        check_output("lock_count", wr_count - base, 1);
        check_output("lock_addr", entry[7:1], 123);
        check_output("lock_data", entry[0], 1);
        check_board("lock_board");

        // Lateral moves and the left wall.
        for (int t = 0; t < 3; t++) apply_stimulus(1'b1, 1'b0);
        check_output("left_3", block_x, 0);
        apply_stimulus(1'b1, 1'b0);
        check_output("left_wall", block_x, 0);
        apply_stimulus(1'b0, 1'b1);
        x0 = m_x;
        apply_stimulus(1'b1, 1'b1);
        check_output("both_held", block_x, x0);

        // Random play on a partially filled lower board.
        for (int y = 9; y < H; y++)
            for (int x = 0; x < W; x++)
                if ($urandom_range(0, 3) == 0) preload_cell(x, y);
        for (int t = 0; t < 1200; t++)
            apply_stimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        check_board("random_board");

        // Completing row 15 from the right edge clears it and scores.
        @(negedge clock);
        reset = 1'b1;
        release_and_check_clear();
        for (int x = 0; x < 7; x++) preload_cell(x, 15);
        for (int t = 0; t < 4; t++) apply_stimulus(1'b0, 1'b1);
        check_output("right_edge", block_x, 7);
        for (int t = 4; t < 16 * FF - 1; t++) apply_stimulus(1'b0, 1'b0);
        base = wr_count;
        apply_stimulus(1'b0, 1'b0);
        check_output("rowclr_count", wr_count - base, 9);
        entry = wr_log[base % 256];
        check_output("rowclr_lock", {24'd0, entry}, {24'd0, 7'd127, 1'b1});
        for (int i = 1; i < 9; i++) begin
            entry = wr_log[(base + i) % 256];
            check_output("rowclr_wr", {24'd0, entry}, {24'd0, 7'(119 + i), 1'b0});
        end
        check_output("rowclr_score", score, 1);
        check_board("rowclr_board");

        // Reset landing in the middle of a row clear.
        for (int x = 0; x < W; x++) if (x != SPX) preload_cell(x, 15);
        for (int t = 0; t < 16 * FF - 1; t++) apply_stimulus(1'b0, 1'b0);
        @(negedge clock);
        frame_tick = 1'b1;
        move_left  = 1'b0;
        move_right = 1'b0;
        @(negedge clock);
        frame_tick = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (mem_wr && !mem_wdata) begin
                found = 1'b1;
                break;
            end
            @(negedge clock);
        end
        check_output("rowclr_seen", found, 1);
        reset = 1'b1;
        #1;
        check_reset_values("midrst");
        release_and_check_clear();

        // A stacked spawn column ends the game; nothing moves or writes afterwards.
        for (int y = 1; y < H; y++) preload_cell(SPX, y);
        for (int t = 0; t < FF - 1; t++) apply_stimulus(1'b0, 1'b0);
        base = wr_count;
        apply_stimulus(1'b0, 1'b0);
        entry = wr_log[base % 256];
        check_output("over_lock_count", wr_count - base, 1);
        check_output("over_lock_addr", entry[7:1], SPX);
        check_output("over_flag", game_over, 1);
        check_output("over_busy", busy, 1);
        base = wr_count;
        for (int t = 0; t < 10; t++)
            apply_stimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        check_output("over_no_writes", wr_count - base, 0);
        check_output("over_busy_hold", busy, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/block_fall_controller.md
Name: block_fall_controller

Overview:
- Game sequencer for BlockFall: moves a single-cell falling block over a WIDTH x HEIGHT board.
- Owns the single port of a 1-bit-per-cell board RAM. The VGA renderer reads a shadow copy of that RAM; the shadow copy is outside this block.
- Paced by a once-per-frame tick. Handles lateral moves, gravity, locking, full-row clearing, scoring and game-over.

Parameters:
- WIDTH, 8, board columns (>=2).
- HEIGHT, 16, board rows (>=2).
- XBITS, 3, width of block_x; 2^XBITS >= WIDTH.
- YBITS, 4, width of block_y; 2^YBITS >= HEIGHT.
- ADDR_BITS, 7, RAM address width; 2^ADDR_BITS >= WIDTH*HEIGHT.
- FALL_FRAMES, 30, frame ticks per gravity step (>=1).
- SPAWN_X, 3, spawn column (< WIDTH).

Ports:
- clock  in  1  system clock (cm_clock0 domain).
- reset  in  1  asynchronous, active-high.
- frame_tick  in  1  one-cycle pulse per VGA frame.
- move_left  in  1  level, sampled on frame_tick.
- move_right  in  1  level, sampled on frame_tick.
- mem_addr  out  ADDR_BITS  cell address = y*WIDTH + x.
- mem_wr  out  1  write strobe.
- mem_wdata  out  1  write data; 1 = occupied.
- mem_rdata  in  1  read data, valid the cycle after mem_addr is driven (1-cycle latency).
- block_x  out  XBITS  falling block column.
- block_y  out  YBITS  falling block row; 0 = top.
- score  out  16  cleared rows, saturating.
- game_over  out  1  high in OVER state.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset values:
  - state = CLEAR.
  - block_x = SPAWN_X, block_y = 0.
  - score = 0, game_over = 0, busy = 1.
  - mem_wr = 0, mem_addr = 0, mem_wdata = 0.
  - fall counter = 0.
- Reset asserted mid-operation aborts immediately. Any RAM write in flight is dropped. The board is re-cleared.
- CLEAR:
  - Writes 0 to addresses 0..WIDTH*HEIGHT-1, one per cycle, mem_wr = 1.
  - After the last address -> SPAWN_RD.
- Read protocol: every *_RD state drives mem_addr with mem_wr = 0. The following *_CHK state samples mem_rdata.
- SPAWN_RD/SPAWN_CHK:
  - Read (SPAWN_X, 0).
  - Cell 0: block = (SPAWN_X, 0), fall counter = 0 -> IDLE.
  - Cell 1 -> OVER.
- IDLE (busy = 0): frame_tick is ignored in every state except IDLE. On frame_tick:
  - move_left = 1, move_right = 0, block_x > 0: target = x-1 -> MOVE_RD.
  - move_right = 1, move_left = 0, block_x < WIDTH-1: target = x+1 -> MOVE_RD.
  - Otherwise (none, both, or out of bounds) -> GRAV.
- MOVE_RD/MOVE_CHK:
  - Read (target, y).
  - Cell 0: block_x = target.
  - Either way -> GRAV.
- GRAV (1 cycle):
  - fall counter == FALL_FRAMES-1: counter = 0 -> FALL_RD.
  - Otherwise: counter + 1 -> IDLE.
- FALL_RD/FALL_CHK:
  - If block_y == HEIGHT-1: go directly to LOCK_WR; no read is issued.
  - Otherwise read (x, y+1).
  - Cell 0: block_y + 1 -> IDLE.
  - Cell 1 -> LOCK_WR.
- LOCK_WR:
  - Write 1 at (x, y) for one cycle.
  - Scan column c = 0 -> ROW_RD.
- ROW_RD/ROW_CHK:
  - Read (c, y).
  - Cell 0 -> SPAWN_RD.
  - Cell 1, c < WIDTH-1: c + 1 -> ROW_RD.
  - Cell 1, c == WIDTH-1 -> ROW_CLR.
- ROW_CLR:
  - Writes 0 at (0..WIDTH-1, y), one per cycle.
  - Then score + 1; score holds at 16'hFFFF once reached.
  - -> SPAWN_RD. Rows above the cleared row are not shifted.
- OVER: game_over = 1, busy = 1, no RAM writes. Held until reset.
- mem_wr is asserted only in CLEAR, LOCK_WR and ROW_CLR.
- All address arithmetic is computed at full ADDR_BITS width, with no truncation of y*WIDTH.

Test Plan:
- Reset, then run WIDTH*HEIGHT + 2 cycles -> exactly 128 zero writes to addresses 0..127, then block = (3, 0), busy = 0, game_over = 0.
- 30 frame_ticks with no moves -> block_y goes 0 -> 1 on the 30th tick. After 15*30 ticks block_y = 15; the next gravity step writes 1 at addr 123, and the block respawns at (3, 0).
- move_left held for 3 ticks from x = 3 -> x = 0. A 4th tick keeps x = 0. move_left and move_right both held -> x unchanged.
- Preload row 15 cells 0..6 = 1 (via the RAM model) and drop the block at x = 7 -> LOCK writes addr 127, then zero writes to addrs 120..127, score = 1.
- Preload (3, 0) = 1 before CLEAR finishes is not possible, so instead stack a column at x = 3 up to row 1 and lock at row 0 -> SPAWN_CHK reads 1, game_over = 1. Later ticks and moves cause no writes.
- Assert reset during ROW_CLR -> outputs return to reset values in the same cycle (async), then the CLEAR sequence restarts and score = 0.
